// File: rtl/ttl_bus_pkg.sv
// Shared types and constants for the 74173 register-bank bus sequencer.
package ttl_bus_pkg;

   localparam int DEF_NREG = 4;
   localparam int DEF_NREQ = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      LATCH = 2'd2,
      TURN  = 2'd3
   } bus_state_t;

   // Index width that never collapses to zero bits for a single-entry set.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ttl_bus_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index; priority rotates past each accepted grant.
module rr_arbiter
   import ttl_bus_pkg::*;
#(
   parameter int  N = DEF_NREQ,
   localparam int W = idx_w(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         en,
   input  logic         adv,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_idx
);

   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;
   logic [W-1:0] cand;
   int           sum;

   // Scan from lowest priority to highest so the slot nearest the pointer wins last.
   always_comb begin
      gnt_idx = '0;
      sum     = 0;
      cand    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         sum     = int'(ptr_q) + i;
         cand    = W'((sum >= N) ? sum - N : sum);
         gnt_idx = (en && req[cand]) ? cand : gnt_idx;
      end
      gnt          = '0;
      gnt[gnt_idx] = en && (|req);
      ptr_d        = adv ? W'((int'(gnt_idx) + 1) % N) : ptr_q;
   end

   // Rotation pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ttl_bus_sequencer.sv
// Sequences register-to-register moves on a shared tri-state bus: drive, latch, turnaround.
module ttl_bus_sequencer
   import ttl_bus_pkg::*;
#(
   parameter int  NREG = DEF_NREG,
   parameter int  NREQ = DEF_NREQ,
   localparam int IW   = $clog2(NREG),
   localparam int DW   = idx_w(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*IW-1:0]   req_src,
   input  logic [NREQ*IW-1:0]   req_dst,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREG-1:0]      reg_oe_n,
   output logic [NREG-1:0]      reg_ld_n,
   output logic                 done,
   output logic                 err,
   output logic [DW-1:0]        done_id,
   output logic                 busy
);

   bus_state_t      state_q, state_d;
   logic [IW-1:0]   src_q, src_d, dst_q, dst_d;
   logic [DW-1:0]   id_q, id_d;
   logic            bad_q, bad_d;
   logic [NREG-1:0] oe_n_q, oe_n_d, ld_n_q, ld_n_d;
   logic            done_q, done_d, err_q, err_d, busy_q, busy_d;
   logic [DW-1:0]   done_id_q, done_id_d;

   logic [DW-1:0]   gnt_idx;
   logic [IW-1:0]   sel_src, sel_dst;
   logic            sel_bad, accept, arb_en;

   assign arb_en  = (state_q == IDLE) || (state_q == TURN);
   assign accept  = |req_ready;
   assign sel_src = req_src[gnt_idx*IW +: IW];
   assign sel_dst = req_dst[gnt_idx*IW +: IW];
   assign sel_bad = (sel_src == sel_dst) || (32'(sel_src) >= 32'(NREG)) || (32'(sel_dst) >= 32'(NREG));

   rr_arbiter #(.N(NREQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .en      (arb_en),
      .adv     (accept),
      .gnt     (req_ready),
      .gnt_idx (gnt_idx)
   );

   // Next state and capture of the accepted request.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      id_d    = id_q;
      bad_d   = bad_q;
      case (state_q)
         IDLE, TURN: begin
            if (accept) begin
               src_d   = sel_src;
               dst_d   = sel_dst;
               id_d    = gnt_idx;
               bad_d   = sel_bad;
               state_d = sel_bad ? TURN : DRIVE;
            end else begin
               state_d = IDLE;
            end
         end
         DRIVE:   state_d = LATCH;
         LATCH:   state_d = TURN;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the upcoming state so every pin comes straight off a flop.
   always_comb begin
      oe_n_d    = '1;
      ld_n_d    = '1;
      done_d    = 1'b0;
      err_d     = 1'b0;
      done_id_d = done_id_q;
      busy_d    = (state_d != IDLE);
      case (state_d)
         DRIVE: oe_n_d[src_d] = 1'b0;
         LATCH: begin
            oe_n_d[src_d] = 1'b0;
            ld_n_d[dst_d] = 1'b0;
         end
         TURN: begin
            done_d    = 1'b1;
            err_d     = bad_d;
            done_id_d = id_d;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // State, capture and output registers; reset releases every enable at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         id_q      <= '0;
         bad_q     <= 1'b0;
         oe_n_q    <= '1;
         ld_n_q    <= '1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         done_id_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         id_q      <= id_d;
         bad_q     <= bad_d;
         oe_n_q    <= oe_n_d;
         ld_n_q    <= ld_n_d;
         done_q    <= done_d;
         err_q     <= err_d;
         done_id_q <= done_id_d;
         busy_q    <= busy_d;
      end
   end

   assign reg_oe_n = oe_n_q;
   assign reg_ld_n = ld_n_q;
   assign done     = done_q;
   assign err      = err_q;
   assign done_id  = done_id_q;
   assign busy     = busy_q;

endmodule

// File: doc/ttl_bus_sequencer.md
# ttl_bus_sequencer

Sequences register-to-register transfers over the shared 4-bit tri-state bus formed by a bank of 74173-style registers. It drives each register's active-low output-enable and load-enable pins, so that at most one register ever drives the bus and loads happen only on a stable bus. It arbitrates transfer requests from several requesters round-robin. It sits between the microsequencer/front-panel logic and the register bank.

## Interface
- `NREG`, 4: number of bus registers; must be 2..16.
- `NREQ`, 2: number of requesters; must be 1..8.
- `IW`, `$clog2(NREG)`: register index width, derived; not overridden.
- `clk` input 1: single system clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req_valid` input `NREQ`: per-requester transfer request.
- `req_src` input `NREQ*IW`: source register index, packed; requester i at `[i*IW +: IW]`.
- `req_dst` input `NREQ*IW`: destination register index, same packing.
- `req_ready` output `NREQ`: one-hot grant; the request is accepted at an edge where `req_valid[i] & req_ready[i]`.
- `reg_oe_n` output `NREG`: active-low output enable per register; ties to both `oe1` and `oe2`.
- `reg_ld_n` output `NREG`: active-low load enable per register; ties to both `e1` and `e2`.
- `done` output 1: one-cycle pulse when a transfer completes.
- `err` output 1: one-cycle pulse with `done` for an illegal request.
- `done_id` output `$clog2(NREQ)` (min 1): requester that owned the completed transfer.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, DRIVE, LATCH, TURN.
- **IDLE**
  - Arbiter grants the highest-priority valid requester; `req_ready` is one-hot for that requester.
  - On acceptance, capture src, dst and id, then go to DRIVE.
  - If the accepted request has src==dst or either index >= NREG, go to TURN with `err` set instead.
- **DRIVE:** `reg_oe_n[src]`=0 (bus settle); then go to LATCH.
- **LATCH:** `reg_oe_n[src]`=0 and `reg_ld_n[dst]`=0. The destination captures the bus on the edge that ends LATCH. Then go to TURN.
- **TURN:** all enables high (bus turnaround); `done`=1; `done_id` valid; `err` as captured.
  - The arbiter is also active in TURN. An accepted request goes directly to DRIVE (or to TURN again if illegal).
  - With no acceptance, go to IDLE.
- **Round-robin:** on each acceptance, priority moves to the requester after the granted one (mod NREQ). Pointer resets to 0.
- **Invariants**
  - At most one `reg_oe_n` bit is low in any cycle.
  - A `reg_ld_n` bit is low only while exactly one `oe_n` bit is low, and never for the driving register.
  - `req_ready` is all-zero in DRIVE and LATCH.
- **Reset values (asynchronous):** state=IDLE, `reg_oe_n`=all 1, `reg_ld_n`=all 1, `done`=0, `err`=0, `done_id`=0, `busy`=0, RR pointer=0. `req_ready` reflects the arbiter in IDLE right after reset.
- **Reset mid-transfer:** enables release immediately. No load completes unless its edge came before `rst` rose.

## Timing
- All outputs except `req_ready` are registered, with no combinational path from inputs.
- `req_ready` is combinational from `req_valid`, the state and the RR pointer.
- **Single transfer, accepted at edge T0:**
  - DRIVE during T0..T1.
  - LATCH during T1..T2; dst loads at T2.
  - TURN during T2..T3, with `done` high.
  - Source-to-destination latency is 2 edges; `done` appears 2 cycles after acceptance.
- **Back-to-back:** sustained throughput is one transfer per 3 cycles.
- **Illegal request:** accepted at T0; `done` and `err` are high during T0..T1; no enables ever go low.
- Requesters must hold `req_src`/`req_dst` stable only while `req_valid` is high and not yet accepted.
- `req_valid` may drop without acceptance; nothing is latched in that case.

## Structure
- Shared package `ttl_bus_pkg` holds:
  - the state enum `bus_state_t` (IDLE, DRIVE, LATCH, TURN);
  - the index-width helper function;
  - the default `NREG` and `NREQ` constants.
- One sub-module: `rr_arbiter`, parameterised on N.
  - Inputs: request vector, enable, advance.
  - Outputs: one-hot grant and encoded grant index.
- Top level contains the FSM, the capture registers and the one-hot enable decoders.

## Test plan
- **Reset:** assert `rst` mid-LATCH of transfer src=1, dst=2 → on the same edge `reg_oe_n`=4'b1111 and `reg_ld_n`=4'b1111; reg2 keeps its prior value; `busy`=0.
- **Single transfer:** reg0=4'hA, req0 src=0 dst=3 accepted at T0 → `reg_oe_n`=4'b1110 at T0+1 and T0+2; `reg_ld_n`=4'b0111 at T0+2 only; reg3=4'hA after T2; `done`=1 with `done_id`=0 at T0+3.
- **Contention:** `req_valid`=2'b11 held continuously with pointer 0 → grants alternate 0,1,0,1 every 3 cycles; `err` never asserts.
- **Illegal:** req1 src=2 dst=2 → accepted; next cycle `done`=1, `err`=1, `done_id`=1; no `oe_n` or `ld_n` bit ever goes low.
- **Invariant sweep:** random legal requests for 10k cycles with a bus monitor → never more than one `oe_n` low; no `ld_n` low without a driver; every accepted request produces exactly one `done`.
- **Withdraw:** req0 valid for 1 cycle in DRIVE, then dropped → not accepted; FSM completes the current transfer and returns to IDLE.
